// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Control stage in front of the Argon ALU. It takes one command {op, A, B},
//   loads it into the ALU over the shared bus in the order the ALU requires
//   (op, A, optional B, optional flags), pulses outputY and then outputF to
//   read back the result and the flags, and returns both on a valid/ready
//   response channel.
//
//   Optional build macro: ARGON_SEQ_FLAGS_PRELOAD_EN
//     Defined  : adds i_cmd_load_f / i_cmd_flags. A command with load_f set
//                loads the flags word (S_LD_F) after its last operand and
//                before S_EXEC, so ADC/SBC can use a chosen carry-in.
//     Undefined: no preload ports; o_latchF is always 0.
//
// Ports
//   i_Clk, i_Reset                 clock, synchronous active-high reset
//   i_cmd_valid / o_cmd_ready      command handshake (ready only in S_IDLE)
//   i_cmd_op, i_cmd_a, i_cmd_b     opcode and operands
//   i_cmd_skip_b                   1 = leave the ALU's B register untouched
//   o_bus_data, o_bus_valid        word to the ALU bus_if
//   i_bus_data, i_bus_valid        word from the ALU bus_if
//   o_latchOp/A/B/F                ALU latch strobes
//   o_outputY, o_outputF           ALU output-select strobes
//   o_rsp_valid / i_rsp_ready      response handshake
//   o_rsp_result, o_rsp_flags      captured Y and flags words
//   o_op_count                     completed commands, wraps at 16 bits
module alu_op_sequencer #(
  parameter int WORDSIZE = 16,
  parameter int OPW      = 4
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [OPW-1:0]      i_cmd_op,
  input  logic [WORDSIZE-1:0] i_cmd_a,
  input  logic [WORDSIZE-1:0] i_cmd_b,
  input  logic                i_cmd_skip_b,
`ifdef ARGON_SEQ_FLAGS_PRELOAD_EN
  input  logic                i_cmd_load_f,
  input  logic [WORDSIZE-1:0] i_cmd_flags,
`endif
  output logic [WORDSIZE-1:0] o_bus_data,
  output logic                o_bus_valid,
  input  logic [WORDSIZE-1:0] i_bus_data,
  input  logic                i_bus_valid,
  output logic                o_latchOp,
  output logic                o_latchA,
  output logic                o_latchB,
  output logic                o_latchF,
  output logic                o_outputY,
  output logic                o_outputF,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [WORDSIZE-1:0] o_rsp_result,
  output logic [WORDSIZE-1:0] o_rsp_flags,
  output logic [15:0]         o_op_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LD_OP = 3'd1,
    S_LD_A  = 3'd2,
    S_LD_B  = 3'd3,
    S_LD_F  = 3'd4,
    S_EXEC  = 3'd5,
    S_RD_F  = 3'd6,
    S_RSP   = 3'd7
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  state_t              w_post_load;

  logic [OPW-1:0]      r_op;
  logic [WORDSIZE-1:0] r_a;
  logic [WORDSIZE-1:0] r_b;
  logic                r_skip_b;
  logic [WORDSIZE-1:0] r_rsp_result;
  logic [WORDSIZE-1:0] r_rsp_flags;
  logic [15:0]         r_op_count;

  logic                w_accept;
  logic                w_rsp_fire;

`ifdef ARGON_SEQ_FLAGS_PRELOAD_EN
  logic                r_load_f;
  logic [WORDSIZE-1:0] r_flags_in;

  // State that follows the last operand load.
  assign w_post_load = r_load_f ? S_LD_F : S_EXEC;
`else
  assign w_post_load = S_EXEC;
`endif

  assign w_accept     = o_cmd_ready & i_cmd_valid;
  assign w_rsp_fire   = o_rsp_valid & i_rsp_ready;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_flags  = r_rsp_flags;
  assign o_op_count   = r_op_count;

  // Control state, captured response words and completion counter
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state      <= S_IDLE;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
      r_op_count   <= '0;
    end else begin
      r_state <= w_state_next;
      // A missing bus_valid is a protocol error: the old capture is kept.
      if (r_state == S_EXEC && i_bus_valid) r_rsp_result <= i_bus_data;
      if (r_state == S_RD_F && i_bus_valid) r_rsp_flags  <= i_bus_data;
      if (w_rsp_fire) r_op_count <= r_op_count + 16'd1;
    end
  end

  // Command fields, held for the whole sequence
  always_ff @(posedge i_Clk) begin
    if (w_accept) begin
      r_op     <= i_cmd_op;
      r_a      <= i_cmd_a;
      r_b      <= i_cmd_b;
      r_skip_b <= i_cmd_skip_b;
`ifdef ARGON_SEQ_FLAGS_PRELOAD_EN
      r_load_f   <= i_cmd_load_f;
      r_flags_in <= i_cmd_flags;
`endif
    end
  end

  // Next state and state-decoded outputs: each strobe is high exactly for
  // the cycle its state is current, so at most one is ever active.
  always_comb begin
    w_state_next = r_state;
    o_cmd_ready  = 1'b0;
    o_bus_valid  = 1'b0;
    o_bus_data   = '0;
    o_latchOp    = 1'b0;
    o_latchA     = 1'b0;
    o_latchB     = 1'b0;
    o_latchF     = 1'b0;
    o_outputY    = 1'b0;
    o_outputF    = 1'b0;
    o_rsp_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) w_state_next = S_LD_OP;
      end
      S_LD_OP: begin
        o_bus_valid  = 1'b1;
        o_latchOp    = 1'b1;
        o_bus_data   = WORDSIZE'(r_op);
        w_state_next = S_LD_A;
      end
      S_LD_A: begin
        o_bus_valid  = 1'b1;
        o_latchA     = 1'b1;
        o_bus_data   = r_a;
        w_state_next = r_skip_b ? w_post_load : S_LD_B;
      end
      S_LD_B: begin
        o_bus_valid  = 1'b1;
        o_latchB     = 1'b1;
        o_bus_data   = r_b;
        w_state_next = w_post_load;
      end
`ifdef ARGON_SEQ_FLAGS_PRELOAD_EN
      S_LD_F: begin
        o_bus_valid  = 1'b1;
        o_latchF     = 1'b1;
        o_bus_data   = r_flags_in;
        w_state_next = S_EXEC;
      end
`endif
      S_EXEC: begin
        o_outputY    = 1'b1;
        w_state_next = S_RD_F;
      end
      S_RD_F: begin
        o_outputF    = 1'b1;
        w_state_next = S_RSP;
      end
      S_RSP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
`timescale 1ns/1ps
module tb_alu_op_sequencer;
  localparam int W   = 16;
  localparam int OPW = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           i_cmd_valid = 1'b0;
  logic           o_cmd_ready;
  logic [OPW-1:0] i_cmd_op = '0;
  logic [W-1:0]   i_cmd_a = '0;
  logic [W-1:0]   i_cmd_b = '0;
  logic           i_cmd_skip_b = 1'b0;
`ifdef ARGON_SEQ_FLAGS_PRELOAD_EN
  logic           i_cmd_load_f = 1'b0;
  logic [W-1:0]   i_cmd_flags = '0;
`endif
  logic [W-1:0]   o_bus_data;
  logic           o_bus_valid;
  logic [W-1:0]   i_bus_data;
  logic           i_bus_valid;
  logic           o_latchOp, o_latchA, o_latchB, o_latchF, o_outputY, o_outputF;
  logic           o_rsp_valid;
  logic           i_rsp_ready = 1'b0;
  logic [W-1:0]   o_rsp_result, o_rsp_flags;
  logic [15:0]    o_op_count;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WORDSIZE(W), .OPW(OPW)) dut (
    .i_Clk(clk), .i_Reset(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_op(i_cmd_op), .i_cmd_a(i_cmd_a), .i_cmd_b(i_cmd_b),
    .i_cmd_skip_b(i_cmd_skip_b),
`ifdef ARGON_SEQ_FLAGS_PRELOAD_EN
    .i_cmd_load_f(i_cmd_load_f), .i_cmd_flags(i_cmd_flags),
`endif
    .o_bus_data(o_bus_data), .o_bus_valid(o_bus_valid),
    .i_bus_data(i_bus_data), .i_bus_valid(i_bus_valid),
    .o_latchOp(o_latchOp), .o_latchA(o_latchA), .o_latchB(o_latchB),
    .o_latchF(o_latchF), .o_outputY(o_outputY), .o_outputF(o_outputF),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_result(o_rsp_result), .o_rsp_flags(o_rsp_flags),
    .o_op_count(o_op_count)
  );

  // ALU operation table. Flags word: bit0 CARRY, bit1 ZERO, bit2 NEG.
  // Opcodes: 0 ADD, 1 SUB, 2 INC, 3 DEC, 4 ADC, 5 AND, 6 OR, 7 XOR, else pass A.
  function automatic logic [2*W-1:0] alu_fn(input logic [OPW-1:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic cin);
    logic [W:0]   s;
    logic [W-1:0] y;
    case (op)
      4'd0:    s = {1'b0, a} + {1'b0, b};
      4'd1:    s = {1'b0, a} - {1'b0, b};
      4'd2:    s = {1'b0, a} + 17'd1;
      4'd3:    s = {1'b0, a} - 17'd1;
      4'd4:    s = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      4'd5:    s = {1'b0, a & b};
      4'd6:    s = {1'b0, a | b};
      4'd7:    s = {1'b0, a ^ b};
      default: s = {1'b0, a};
    endcase
    y = s[W-1:0];
    return {13'd0, y[W-1], (y == '0), s[W], y};
  endfunction

  // ALU attached to the bus: latches on strobes, flags update at end of outputY.
  logic [OPW-1:0] alu_op = '0;
  logic [W-1:0]   alu_a = '0, alu_b = '0, alu_f = '0;
  logic [2*W-1:0] alu_out;
  assign alu_out     = alu_fn(alu_op, alu_a, alu_b, alu_f[0]);
  assign i_bus_data  = o_outputY ? alu_out[W-1:0] : (o_outputF ? alu_f : '0);
  assign i_bus_valid = o_outputY | o_outputF;

  always @(posedge clk) begin
    if (o_bus_valid && o_latchOp) alu_op <= o_bus_data[OPW-1:0];
    if (o_bus_valid && o_latchA)  alu_a  <= o_bus_data;
    if (o_bus_valid && o_latchB)  alu_b  <= o_bus_data;
    if (o_bus_valid && o_latchF)  alu_f  <= o_bus_data;
    if (o_outputY)                alu_f  <= alu_out[2*W-1:W];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] flg;
    int           acc;
    int           lat;
    logic [31:0]  seq;
  } exp_t;
  exp_t exp_q[$];

  // Reference state: what the ALU should still hold between commands.
  logic [W-1:0] ref_b = '0;
  logic [W-1:0] ref_flags = '0;

  // Response ready: 0 random, 1 always high, 2 held low. Changes after posedge.
  int rdy_mode = 1;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       i_rsp_ready = ($urandom_range(0, 2) != 0);
      1:       i_rsp_ready = 1'b1;
      default: i_rsp_ready = 1'b0;
    endcase
  end

  // Monitor / scoreboard
  logic [31:0] mseq = '0;
  logic        mviol = 1'b0;
  logic        prev_rv = 1'b0;
  logic        hs_pend = 1'b0;
  logic [15:0] exp_count = '0;
  logic [W-1:0] last_res = '0, last_flg = '0;
  int          last_hs = 0;

  always @(negedge clk) begin
    int n;
    logic [3:0] code;
    exp_t e;
    if (rst) begin
      mseq = '0; mviol = 1'b0; prev_rv = 1'b0; hs_pend = 1'b0;
      exp_count = '0;
      exp_q.delete();
    end else begin
      if (hs_pend) begin
        exp_count = exp_count + 16'd1;
        chk("op_count", 32'(o_op_count), 32'(exp_count));
        hs_pend = 1'b0;
      end
      n = int'(o_latchOp) + int'(o_latchA) + int'(o_latchB) + int'(o_latchF)
        + int'(o_outputY) + int'(o_outputF);
      code = o_latchOp ? 4'd1 : o_latchA ? 4'd2 : o_latchB ? 4'd3 :
             o_latchF ? 4'd4 : o_outputY ? 4'd5 : o_outputF ? 4'd6 : 4'd0;
      if (n > 1) mviol = 1'b1;
      if ((n > 0 || o_bus_valid) && (o_cmd_ready || o_rsp_valid)) mviol = 1'b1;
      if (o_bus_valid !== (o_latchOp | o_latchA | o_latchB | o_latchF)) mviol = 1'b1;
      if (n == 1) mseq = (mseq << 4) | 32'(code);
      if (o_rsp_valid && !prev_rv) begin
        if (exp_q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
        else chk("latency", 32'(cyc - exp_q[0].acc), 32'(exp_q[0].lat));
      end
      if (o_rsp_valid && i_rsp_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("result", 32'(o_rsp_result), 32'(e.res));
        chk("flags", 32'(o_rsp_flags), 32'(e.flg));
        chk("strobe_order", mseq, e.seq);
        chk("strobe_protocol", 32'(mviol), 32'd0);
        last_res = o_rsp_result;
        last_flg = o_rsp_flags;
        mseq = '0; mviol = 1'b0;
        hs_pend = 1'b1;
        last_hs = cyc + 1;
      end
      prev_rv = o_rsp_valid;
    end
  end

  int last_acc = 0;

  task automatic send(input logic [OPW-1:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic skip,
                      input logic lf_req, input logic [W-1:0] fl);
    int n = 0;
    logic lf;
    exp_t e;
    logic [2*W-1:0] r;
`ifdef ARGON_SEQ_FLAGS_PRELOAD_EN
    lf = lf_req;
`else
    lf = 1'b0;
    if (lf_req) lf = 1'b0;
`endif
    @(negedge clk);
    while (!o_cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (!o_cmd_ready) begin
      chk("cmd_ready_timeout", 32'd0, 32'd1);
      return;
    end
    i_cmd_op = op; i_cmd_a = a; i_cmd_b = b; i_cmd_skip_b = skip;
`ifdef ARGON_SEQ_FLAGS_PRELOAD_EN
    i_cmd_load_f = lf; i_cmd_flags = fl;
`endif
    i_cmd_valid = 1'b1;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    i_cmd_a = W'($urandom); i_cmd_b = W'($urandom);
    last_acc = cyc;
    r = alu_fn(op, a, skip ? ref_b : b, lf ? fl[0] : ref_flags[0]);
    if (!skip) ref_b = b;
    ref_flags = r[2*W-1:W];
    e.res = r[W-1:0];
    e.flg = r[2*W-1:W];
    e.acc = cyc;
    e.lat = 4 + (skip ? 0 : 1) + (lf ? 1 : 0);
    e.seq = 32'h12;
    if (!skip) e.seq = (e.seq << 4) | 32'h3;
    if (lf)    e.seq = (e.seq << 4) | 32'h4;
    e.seq = (e.seq << 8) | 32'h56;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || !o_cmd_ready) && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [W-1:0] sres, sflg;
    logic [15:0]  scnt;
    logic         ok;
    int           n;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_outputs", {o_bus_valid, o_latchOp, o_latchA, o_latchB, o_latchF,
                        o_outputY, o_outputF}, 32'd0);
    chk("rst_bus_data", 32'(o_bus_data), 32'd0);
    chk("rst_rsp_words", {o_rsp_result, o_rsp_flags}, 32'd0);
    chk("rst_op_count", 32'(o_op_count), 32'd0);
    rst = 1'b0;

    // Directed ALU cases
    rdy_mode = 1;
    send(4'd0, 16'h1234, 16'h0101, 1'b0, 1'b0, 16'h0);
    drain();
    chk("add_result", 32'(last_res), 32'h1335);
    chk("add_flags_zc", 32'(last_flg[1:0]), 32'd0);
    send(4'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0);
    drain();
    chk("carry_result", 32'(last_res), 32'h0000);
    chk("carry_flags_zc", 32'(last_flg[1:0]), 32'd3);
    send(4'd2, 16'h00FF, 16'h5555, 1'b1, 1'b0, 16'h0);
    drain();
    chk("inc_result", 32'(last_res), 32'h0100);
`ifdef ARGON_SEQ_FLAGS_PRELOAD_EN
    send(4'd4, 16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0001);
    drain();
    chk("adc_preload_result", 32'(last_res), 32'h0003);
`endif

    // Backpressure, then back-to-back acceptance
    rdy_mode = 2;
    send(4'd7, 16'hA5A5, 16'h0FF0, 1'b0, 1'b0, 16'h0);
    n = 0;
    while (!o_rsp_valid && n < 50) begin @(negedge clk); n++; end
    chk("bp_rsp_valid_seen", 32'(o_rsp_valid), 32'd1);
    sres = o_rsp_result; sflg = o_rsp_flags; scnt = o_op_count;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ok = o_rsp_valid && !o_cmd_ready && (o_rsp_result == sres) &&
           (o_rsp_flags == sflg) && (o_op_count == scnt);
      chk("bp_hold", 32'(ok), 32'd1);
    end
    rdy_mode = 1;
    send(4'd1, 16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0);
    chk("back_to_back_accept", 32'(last_acc - last_hs), 32'd1);
    drain();

    // Randomized traffic with random response backpressure
    rdy_mode = 0;
    for (int i = 0; i < 40; i++) begin
      send(OPW'($urandom_range(0, 8)), W'($urandom), W'($urandom),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), W'($urandom));
    end
    drain();

    // Reset in the middle of S_LD_B aborts the command
    rdy_mode = 1;
    send(4'd0, 16'h0102, 16'h0304, 1'b0, 1'b0, 16'h0);
    n = 0;
    while (!o_latchB && n < 20) begin @(negedge clk); n++; end
    chk("saw_latchB", 32'(o_latchB), 32'd1);
    rst = 1'b1;
    ref_b = 16'h0304;  // the ALU still latches B on the edge that resets the DUT
    @(negedge clk);
    chk("abort_outputs", {o_bus_valid, o_latchOp, o_latchA, o_latchB, o_latchF,
                          o_outputY, o_outputF, o_rsp_valid}, 32'd0);
    chk("abort_cmd_ready", 32'(o_cmd_ready), 32'd1);
    chk("abort_op_count", 32'(o_op_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (o_rsp_valid || !o_cmd_ready) ok = 1'b0;
    end
    chk("abort_no_rsp", 32'(ok), 32'd1);

    // Traffic resumes cleanly after the abort
    send(4'd3, 16'h0000, 16'h1111, 1'b1, 1'b0, 16'h0);
    drain();
    chk("dec_result", 32'(last_res), 32'hFFFF);
    send(4'd0, 16'h0007, 16'h0009, 1'b0, 1'b0, 16'h0);
    drain();
    chk("post_abort_count", 32'(o_op_count), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Upstream control stage for the Argon ALU. It accepts one ALU command {op, A, B} on a valid/ready interface.
- It drives the shared bus and the ALU latch/output strobes in the fixed order the ALU requires, then captures the result word and the flags word.
- It returns both on a valid/ready response interface.
- It sits between the instruction decode/control unit and the ALU bus_if.

Parameters:
- WORDSIZE, 16, bus/data word width; the ALU result is WORDSIZE bits.
- OPW, 4, opcode width; matches the ALU op register.

Ports:
- i_Clk  in  1  system clock; all state changes on rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_cmd_valid  in  1  command offered.
- o_cmd_ready  out  1  sequencer can accept a command (high only in S_IDLE).
- i_cmd_op  in  OPW  ALU opcode.
- i_cmd_a  in  WORDSIZE  operand A.
- i_cmd_b  in  WORDSIZE  operand B.
- i_cmd_skip_b  in  1  1 = do not load B (unary ops such as INC/DEC); the ALU keeps its previous B.
- o_bus_data  out  WORDSIZE  word driven to ALU bus_if.i_data.
- o_bus_valid  out  1  to ALU bus_if.i_valid.
- i_bus_data  in  WORDSIZE  from ALU bus_if.o_data.
- i_bus_valid  in  1  from ALU bus_if.o_valid.
- o_latchOp, o_latchA, o_latchB, o_latchF  out  1 each  ALU latch strobes.
- o_outputY, o_outputF  out  1 each  ALU output-select strobes.
- o_rsp_valid  out  1  response available.
- i_rsp_ready  in  1  consumer accepts response.
- o_rsp_result  out  WORDSIZE  captured Y.
- o_rsp_flags  out  WORDSIZE  captured flags word.
- o_op_count  out  16  completed commands, wraps 16'hFFFF -> 0.

Behaviour:
- Reset (sync, i_Reset=1 at edge):
  - state=S_IDLE.
  - All strobes, o_bus_valid, o_rsp_valid = 0.
  - o_bus_data, o_rsp_result, o_rsp_flags, o_op_count = 0.
  - Reset mid-operation aborts the command. No response is produced, and strobes are 0 from the cycle after the reset edge.
- Command handshake:
  - Accepted on the edge where i_cmd_valid & o_cmd_ready.
  - op/A/B/skip_b are registered internally at acceptance.
- States, one cycle each unless stated. Outputs are registered from state, so each strobe is high for exactly the cycle the state is current:
  - S_IDLE: o_cmd_ready=1. Goes to S_LD_OP on accept.
  - S_LD_OP: o_bus_valid=1, o_latchOp=1, o_bus_data={zero-extend, op} -> S_LD_A.
  - S_LD_A: o_bus_valid=1, o_latchA=1, o_bus_data=A. Goes to S_LD_B, or to S_EXEC if skip_b (S_LD_F if FLAGS_PRELOAD_EN and load_f set).
  - S_LD_B: o_bus_valid=1, o_latchB=1, o_bus_data=B. Goes to S_EXEC (or S_LD_F, see optional feature).
  - S_EXEC: o_bus_valid=0, o_outputY=1.
    - The ALU updates its flags at the end of this cycle.
    - o_rsp_result <= i_bus_data at the edge ending the cycle, if i_bus_valid.
    - Goes to S_RD_F.
  - S_RD_F: o_bus_valid=0, o_outputF=1.
    - o_rsp_flags <= i_bus_data at the edge ending the cycle.
    - Goes to S_RSP.
  - S_RSP: o_rsp_valid=1. Result and flags are held stable.
    - On i_rsp_ready: o_op_count increments and state goes to S_IDLE.
    - Otherwise stay in S_RSP. No bus activity in this state, so the ALU is untouched apart from its own idle update.
- Only one latch/output strobe is ever high in a cycle. Strobes and o_bus_valid are never high in S_IDLE or S_RSP.
- Latency, accept edge to o_rsp_valid high: 5 cycles with B loaded, 4 with skip_b.
- Back-to-back: a new command can be accepted one cycle after the response handshake (the S_IDLE cycle). Peak throughput is 1 command per 6 cycles.
- If i_bus_valid=0 in S_EXEC or S_RD_F, the corresponding capture register keeps its old value. Protocol error; no retry.

Optional Feature:
- Macro ARGON_SEQ_FLAGS_PRELOAD_EN.
- Defined:
  - Adds ports i_cmd_load_f (1) and i_cmd_flags (WORDSIZE).
  - When load_f=1 at accept, state S_LD_F (o_bus_valid=1, o_latchF=1, o_bus_data=flags) is inserted after the last operand load, before S_EXEC. This lets ADC/SBC use a chosen carry-in.
  - Adds 1 cycle of latency.
- Not defined: no such ports, S_LD_F unreachable, o_latchF tied 0.

Test Plan:
- Reset: assert i_Reset for 2 cycles mid-S_LD_B -> all strobes 0 the next cycle, o_cmd_ready=1, o_op_count=0, no o_rsp_valid.
- ADD: op=ADD, A=16'h1234, B=16'h0101, ALU model attached -> strobe order latchOp, latchA, latchB, outputY, outputF. o_rsp_result=16'h1335; flags ZERO=0, CARRY=0; rsp_valid 5 cycles after accept.
- Carry/zero: ADD A=16'hFFFF, B=16'h0001 -> result 16'h0000, flags CARRY=1, ZERO=1.
- Unary: INC A=16'h00FF, skip_b=1 -> no latchB pulse, result 16'h0100, latency 4.
- Backpressure: hold i_rsp_ready=0 for 10 cycles -> o_rsp_valid stays 1 with result/flags stable, o_cmd_ready=0, o_op_count unchanged. Counter increments on release; next command accepted the following cycle.
- With ARGON_SEQ_FLAGS_PRELOAD_EN: ADC A=16'h0001, B=16'h0001, load_f=1, flags CARRY=1 -> latchF pulse before outputY, result 16'h0003, latency 6.
